valu_sequencer: RTL and testbench
=================================

# valu_sequencer

Command-side sequencer for the vector ALU array (`ALU_VECTORIAL`).
- Accepts one vector operation over a valid/ready handshake: `N_ELEM` element pairs plus an op select.
- Issues the elements to the `N_ALU` lanes in successive passes and waits out the ALU latency each pass.
- Assembles the `2*WIDTH`-bit lane results into one result vector, returned over a second valid/ready handshake.
- Sits between the command source (CPU/test harness) and the ALU array; drives its `a`, `b`, `select` and `enable` inputs and reads its `data_out`.

## Interface
- `WIDTH`, 4, element width in bits
- `N_ALU`, 1, number of ALU lanes driven per pass
- `N_ELEM`, 4, elements per command (≥1; need not be a multiple of `N_ALU`)
- `ALU_LAT`, 1, cycles from ALU `enable` edge to valid `data_out` (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer idle, command accepted on `cmd_valid && cmd_ready`
- `cmd_select`  in  3  ALU op, passed through unmodified
- `cmd_a`, `cmd_b`  in  `WIDTH*N_ELEM`  operand vectors, element k at `[k*WIDTH +: WIDTH]`
- `res_valid`  out  1  result vector available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  `2*WIDTH*N_ELEM`  results, element k at `[k*2*WIDTH +: 2*WIDTH]`
- `alu_a`, `alu_b`  out  `WIDTH*N_ALU`  lane operands
- `alu_select`  out  3  lane op
- `alu_enable`  out  `N_ALU`  per-lane enable
- `alu_data_out`  in  `2*WIDTH*N_ALU`  lane results, lane i at `[i*2*WIDTH +: 2*WIDTH]`
- `busy`  out  1  high in any state other than IDLE

## Operation
- Number of passes: `P = ceil(N_ELEM/N_ALU)`. In pass p, lane i carries element `p*N_ALU+i`.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** `cmd_ready=1`. On handshake, latch `cmd_a`, `cmd_b`, `cmd_select`; set pass=0; go to ISSUE.
- **ISSUE (1 cycle):**
  - Drive `alu_a`/`alu_b` with the pass-p elements and `alu_select` with the latched op.
  - `alu_enable[i]=1` iff `p*N_ALU+i < N_ELEM`; inactive lanes get a=b=0.
  - Load the wait counter with `ALU_LAT-1`; go to WAIT.
- **WAIT:**
  - Count down. In the cycle the counter reads 0, capture enabled lanes of `alu_data_out` into the `res_data` slots for pass p; inactive lanes are discarded.
  - If p==P-1, go to DONE; else increment p and go to ISSUE.
- **DONE:** `res_valid=1`, `res_data` held stable. On `res_valid && res_ready`, go to IDLE.
- Signal behaviour outside ISSUE:
  - `alu_enable=0`.
  - `alu_a`, `alu_b`, `alu_select` hold their last values.
- `cmd_ready` is combinational from state (IDLE only). No command is accepted in the DONE handshake cycle; the earliest next accept is the following cycle.
- Values of `cmd_*` outside the accept cycle are ignored.
- Unused select encodings are passed through; no checking.
- **Reset (`rst=0` at an edge), including mid-operation:**
  - State goes to IDLE; any in-flight command is dropped and `res_valid` is never raised for it.
  - `res_data`, `alu_a`, `alu_b`, `alu_select`, `alu_enable`, pass and counter are cleared to 0.
- Reset values: `cmd_ready=1` (IDLE), `res_valid=0`, `res_data=0`, `alu_*=0`, `busy=0`.

## Timing
- Accept at edge T, then:
  - First ISSUE cycle is T+1.
  - Pass p ISSUE cycle is `T+1+p*(1+ALU_LAT)`.
  - Capture at the end of cycle `ISSUE+ALU_LAT`.
- `res_valid` first high in cycle `T+1+P*(1+ALU_LAT)`.
- Throughput: one command per `P*(1+ALU_LAT)+2` cycles with `res_ready` held high.
- All outputs are registered except `cmd_ready` and `busy` (decoded from state).

## Structure
- `valu_pkg`: state enum (IDLE/ISSUE/WAIT/DONE), 3-bit op select constants shared with the ALU, and a `passes(N_ELEM,N_ALU)` constant function.
- No sub-module required. The wait counter and pass counter are local registers; counter widths are `$clog2` of `ALU_LAT` and of `P`, each at least 1 bit.

## Test plan
Bench uses `WIDTH=4`, `N_ALU=2`, `N_ELEM=4`, `ALU_LAT=1`, plus a stub ALU that registers `a+b` zero-extended to 8 bits when enabled and holds otherwise.
1. **Reset:** `rst=0` for 2 cycles, then 1 → `cmd_ready=1`, `res_valid=0`, `alu_enable=2'b00`, `res_data=0`, `busy=0`.
2. **Basic command:** a elements {3,7,9,F}, b elements {1,2,9,1}, select=0, accepted at T → `alu_enable=2'b11` at T+1 and T+3; `res_valid` at T+5; `res_data={8'h10,8'h12,8'h09,8'h04}`.
3. **Partial pass:** `N_ELEM=3`, a {1,2,3}, b {1,1,1} → second-pass `alu_enable=2'b01`, lane1 a=b=0; `res_data={8'h04,8'h03,8'h02}`.
4. **Backpressure:** `res_ready=0` for 5 cycles after `res_valid` → `res_valid` and `res_data` stable, `cmd_ready=0`; a pending `cmd_valid` is accepted exactly one cycle after the result handshake.
5. **Reset mid-operation:** `rst=0` during the second-pass WAIT → next cycle state IDLE, `alu_enable=0`, `res_data=0`, no `res_valid` pulse.
6. **Longer latency:** `ALU_LAT=3`, command as in scenario 2 → ISSUE at T+1 and T+5; `res_valid` at T+9; same `res_data`.

Source files
------------

// File: rtl/valu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : valu_pkg
//  Description : Shared types for the vector-ALU command sequencer:
//                sequencer state encoding, the 3-bit ALU op-select encodings
//                shared with ALU_VECTORIAL, and the pass-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package valu_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Op-select encodings understood by the ALU lanes. The sequencer passes
    // the select through untouched, so unlisted codes are still forwarded.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5
    } alu_op_t;

    // Number of lane passes needed to cover n_elem elements with n_alu lanes.
    function automatic int passes(input int n_elem, input int n_alu);
        return (n_elem + n_alu - 1) / n_alu;
    endfunction

endpackage
`default_nettype wire

// File: rtl/valu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : valu_sequencer
//  Description : Command-side sequencer for the vector ALU array. Accepts one
//                N_ELEM-element vector operation, issues it to N_ALU lanes in
//                ceil(N_ELEM/N_ALU) passes, waits ALU_LAT cycles per pass,
//                and returns the assembled 2*WIDTH-bit results.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst              clock; synchronous active-low reset
//    cmd_valid/cmd_ready   command handshake (ready only when idle)
//    cmd_select            ALU op, forwarded unmodified to alu_select
//    cmd_a, cmd_b          operand vectors, element k at [k*WIDTH +: WIDTH]
//    res_valid/res_ready   result handshake
//    res_data              results, element k at [k*2*WIDTH +: 2*WIDTH]
//    alu_a, alu_b          lane operands (registered)
//    alu_select            lane op (registered)
//    alu_enable            per-lane enable, high only during an issue cycle
//    alu_data_out          lane results, lane i at [i*2*WIDTH +: 2*WIDTH]
//    busy                  high whenever not idle
// ============================================================================
module valu_sequencer
    import valu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int N_ALU   = 1,
    parameter int N_ELEM  = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_select,
    input  logic [WIDTH*N_ELEM-1:0]     cmd_a,
    input  logic [WIDTH*N_ELEM-1:0]     cmd_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [2*WIDTH*N_ELEM-1:0]   res_data,
    output logic [WIDTH*N_ALU-1:0]      alu_a,
    output logic [WIDTH*N_ALU-1:0]      alu_b,
    output logic [2:0]                  alu_select,
    output logic [N_ALU-1:0]            alu_enable,
    input  logic [2*WIDTH*N_ALU-1:0]    alu_data_out,
    output logic                        busy
);

    localparam int c_P  = passes(N_ELEM, N_ALU);
    localparam int c_PW = (c_P > 1) ? $clog2(c_P) : 1;
    localparam int c_CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [c_PW-1:0] c_LAST_PASS = c_PW'(c_P - 1);
    localparam logic [c_CW-1:0] c_LAT_M1    = c_CW'(ALU_LAT - 1);

    state_t                     r_state;
    logic [WIDTH*N_ELEM-1:0]    r_a;
    logic [WIDTH*N_ELEM-1:0]    r_b;
    logic [c_PW-1:0]            r_pass;
    logic [c_CW-1:0]            r_cnt;

    logic [c_PW-1:0]            w_issue_pass;
    logic [WIDTH*N_ELEM-1:0]    w_src_a;
    logic [WIDTH*N_ELEM-1:0]    w_src_b;
    logic [WIDTH*N_ALU-1:0]     w_lane_a;
    logic [WIDTH*N_ALU-1:0]     w_lane_b;
    logic [N_ALU-1:0]           w_lane_en;
    logic [N_ALU-1:0]           w_cap_en;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    // Lane operands for the next issue cycle. Leaving IDLE the operands come
    // straight from the command port (the latch happens on the same edge);
    // later passes read the latched copy. Lanes past N_ELEM stay at zero.
    always_comb begin
        w_issue_pass = (r_state == ST_IDLE) ? '0 : r_pass + 1'b1;
        w_src_a      = (r_state == ST_IDLE) ? cmd_a : r_a;
        w_src_b      = (r_state == ST_IDLE) ? cmd_b : r_b;
        w_lane_a     = '0;
        w_lane_b     = '0;
        w_lane_en    = '0;
        w_cap_en     = '0;
        for (int i = 0; i < N_ALU; i++) begin
            if (int'(w_issue_pass) * N_ALU + i < N_ELEM) begin
                w_lane_en[i]                = 1'b1;
                w_lane_a[i*WIDTH +: WIDTH]  = w_src_a[(int'(w_issue_pass) * N_ALU + i) * WIDTH +: WIDTH];
                w_lane_b[i*WIDTH +: WIDTH]  = w_src_b[(int'(w_issue_pass) * N_ALU + i) * WIDTH +: WIDTH];
            end
            // Lanes of the current pass that map onto a real element slot
            if (int'(r_pass) * N_ALU + i < N_ELEM) begin
                w_cap_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_pass     <= '0;
            r_cnt      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= OP_ADD;
            alu_enable <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_a        <= cmd_a;
                        r_b        <= cmd_b;
                        alu_select <= cmd_select;
                        r_pass     <= '0;
                        alu_a      <= w_lane_a;
                        alu_b      <= w_lane_b;
                        alu_enable <= w_lane_en;
                        r_state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    alu_enable <= '0;
                    r_cnt      <= c_LAT_M1;
                    r_state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        for (int i = 0; i < N_ALU; i++) begin
                            if (w_cap_en[i]) begin
                                res_data[(int'(r_pass) * N_ALU + i) * 2 * WIDTH +: 2 * WIDTH]
                                    <= alu_data_out[i*2*WIDTH +: 2*WIDTH];
                            end
                        end
                        if (r_pass == c_LAST_PASS) begin
                            res_valid <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            // Next issue is loaded here so the operands are
                            // already registered in the ISSUE cycle.
                            r_pass     <= w_issue_pass;
                            alu_a      <= w_lane_a;
                            alu_b      <= w_lane_b;
                            alu_enable <= w_lane_en;
                            r_state    <= ST_ISSUE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_valu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_valu_sequencer
//  Description : Testbench for valu_sequencer. Two configurations run side by
//                side: (N_ALU=2, N_ELEM=4, ALU_LAT=1) and (N_ALU=2, N_ELEM=3,
//                ALU_LAT=3), each with a stub ALU that registers a+b.
//                Expected results and timing come from an element-level
//                reference model; a per-cycle monitor compares the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_valu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          t;     // edge number at which the command was accepted
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
    } item_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int W    = 4;
        localparam int NA   = 2;
        localparam int NE   = (k == 0) ? 4 : 3;
        localparam int LAT  = (k == 0) ? 1 : 3;
        localparam int P    = (NE + NA - 1) / NA;
        localparam int SLOT = 1 + LAT;
        localparam int NCMD = 30;

        logic                rst = 1'b0;
        logic                cmd_valid = 1'b0;
        logic                cmd_ready;
        logic [2:0]          cmd_select = '0;
        logic [W*NE-1:0]     cmd_a = '0;
        logic [W*NE-1:0]     cmd_b = '0;
        logic                res_valid;
        logic                res_ready = 1'b0;
        logic [2*W*NE-1:0]   res_data;
        logic [W*NA-1:0]     alu_a;
        logic [W*NA-1:0]     alu_b;
        logic [2:0]          alu_select;
        logic [NA-1:0]       alu_enable;
        logic [2*W*NA-1:0]   alu_data_out;
        logic                busy;

        item_t q[$];
        bit    mon_on   = 1'b0;
        bit    done     = 1'b0;
        bit    rst_evt  = 1'b0;
        int    last_hs  = -10;

        valu_sequencer #(
            .WIDTH   (W),
            .N_ALU   (NA),
            .N_ELEM  (NE),
            .ALU_LAT (LAT)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .cmd_valid    (cmd_valid),
            .cmd_ready    (cmd_ready),
            .cmd_select   (cmd_select),
            .cmd_a        (cmd_a),
            .cmd_b        (cmd_b),
            .res_valid    (res_valid),
            .res_ready    (res_ready),
            .res_data     (res_data),
            .alu_a        (alu_a),
            .alu_b        (alu_b),
            .alu_select   (alu_select),
            .alu_enable   (alu_enable),
            .alu_data_out (alu_data_out),
            .busy         (busy)
        );

        // Stub ALU: registers a+b (zero-extended) on enabled lanes, holds otherwise
        always_ff @(posedge clk) begin
            if (!rst) alu_data_out <= '0;
            else begin
                for (int i = 0; i < NA; i++)
                    if (alu_enable[i])
                        alu_data_out[i*8 +: 8] <= 8'(alu_a[i*4 +: 4]) + 8'(alu_b[i*4 +: 4]);
            end
        end

        // Reference model: each result element is the plain sum of its operands
        function automatic item_t mk(input int t, input logic [2:0] s,
                                     input logic [15:0] a, input logic [15:0] b);
            item_t it;
            it.t   = t;
            it.sel = s;
            it.a   = a;
            it.b   = b;
            it.res = '0;
            for (int e = 0; e < NE; e++)
                it.res[e*8 +: 8] = 8'(int'(a[e*4 +: 4]) + int'(b[e*4 +: 4]));
            return it;
        endfunction

        // ---------------- stimulus ----------------
        logic [15:0] va, vb;
        logic [2:0]  vs;
        bit          waited;
        int          n, t0;

        task automatic send(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                            input int gap);
            @(negedge clk);
            repeat (gap) @(negedge clk);
            cmd_valid  = 1'b1;
            cmd_select = s;
            cmd_a      = a[W*NE-1:0];
            cmd_b      = b[W*NE-1:0];
            waited     = 1'b0;
            n          = 0;
            while (!cmd_ready && n < 200) begin
                waited = 1'b1;
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                fail_now($sformatf("cfg%0d_accept", k));
                cmd_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                q.push_back(mk(cyc, s, a, b));
                if (waited && !rst_evt)
                    chk($sformatf("cfg%0d_accept_after_hs", k), 64'(cyc), 64'(last_hs + 1));
                cmd_valid  = 1'b0;
                cmd_select = 3'($urandom);
                cmd_a      = (W*NE)'($urandom);
                cmd_b      = (W*NE)'($urandom);
            end
        endtask

        task automatic drain();
            n = 0;
            while (q.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) fail_now($sformatf("cfg%0d_drain", k));
        endtask

        initial begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
            chk($sformatf("cfg%0d_rst_cmd_ready", k), 64'(cmd_ready), 64'(1));
            chk($sformatf("cfg%0d_rst_res_valid", k), 64'(res_valid), 64'(0));
            chk($sformatf("cfg%0d_rst_alu_enable", k), 64'(alu_enable), 64'(0));
            chk($sformatf("cfg%0d_rst_res_data", k), 64'(res_data), 64'(0));
            chk($sformatf("cfg%0d_rst_busy", k), 64'(busy), 64'(0));
            mon_on = 1'b1;

            for (int c = 0; c < NCMD; c++) begin
                if (c == 0) begin
                    va = (k == 0) ? 16'hF973 : 16'h0321;
                    vb = (k == 0) ? 16'h1921 : 16'h0111;
                    vs = 3'd0;
                end else begin
                    va = 16'($urandom);
                    vb = 16'($urandom);
                    vs = 3'($urandom);
                end
                send(vs, va, vb, int'($urandom_range(0, 2)));
            end

            // Reset during the second-pass wait of an in-flight command
            drain();
            send(3'd5, 16'hABCD, 16'h1234, 0);
            t0 = q[0].t;
            while (cyc - t0 < SLOT + 1) @(negedge clk);
            rst     = 1'b0;
            rst_evt = 1'b1;
            @(posedge clk);
            #1;
            q.delete();
            rst = 1'b1;
            @(negedge clk);
            chk($sformatf("cfg%0d_mid_rst_res_data", k), 64'(res_data), 64'(0));
            chk($sformatf("cfg%0d_mid_rst_alu_a", k), 64'(alu_a), 64'(0));
            chk($sformatf("cfg%0d_mid_rst_alu_b", k), 64'(alu_b), 64'(0));
            chk($sformatf("cfg%0d_mid_rst_alu_select", k), 64'(alu_select), 64'(0));
            chk($sformatf("cfg%0d_mid_rst_cmd_ready", k), 64'(cmd_ready), 64'(1));
            repeat (6) @(negedge clk);
            rst_evt = 1'b0;

            for (int c = 0; c < 5; c++)
                send(3'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
            drain();
            done = 1'b1;
        end

        // ---------------- monitor / scoreboard ----------------
        item_t             h;
        int                d, p, e;
        int                stall = 0;
        bit                first_res = 1'b1;
        bit                exp_v;
        logic [NA-1:0]     en_e;
        logic [W*NA-1:0]   ae, be;

        always @(negedge clk) begin
            if (mon_on && !done) begin
                if (q.size() == 0) begin
                    chk($sformatf("cfg%0d_idle_cmd_ready", k), 64'(cmd_ready), 64'(1));
                    chk($sformatf("cfg%0d_idle_busy", k), 64'(busy), 64'(0));
                    chk($sformatf("cfg%0d_idle_res_valid", k), 64'(res_valid), 64'(0));
                    chk($sformatf("cfg%0d_idle_alu_enable", k), 64'(alu_enable), 64'(0));
                    res_ready = 1'($urandom_range(0, 1));
                end else begin
                    h = q[0];
                    d = cyc - h.t;
                    chk($sformatf("cfg%0d_busy_cmd_ready", k), 64'(cmd_ready), 64'(0));
                    chk($sformatf("cfg%0d_busy_busy", k), 64'(busy), 64'(1));
                    chk($sformatf("cfg%0d_alu_select", k), 64'(alu_select), 64'(h.sel));
                    en_e = '0;
                    ae   = '0;
                    be   = '0;
                    if ((d % SLOT) == 0 && (d / SLOT) < P) begin
                        p = d / SLOT;
                        for (int i = 0; i < NA; i++) begin
                            e = p * NA + i;
                            if (e < NE) begin
                                en_e[i]      = 1'b1;
                                ae[i*4 +: 4] = h.a[e*4 +: 4];
                                be[i*4 +: 4] = h.b[e*4 +: 4];
                            end
                        end
                        chk($sformatf("cfg%0d_pass%0d_alu_a", k, p), 64'(alu_a), 64'(ae));
                        chk($sformatf("cfg%0d_pass%0d_alu_b", k, p), 64'(alu_b), 64'(be));
                    end
                    chk($sformatf("cfg%0d_alu_enable_d%0d", k, d), 64'(alu_enable), 64'(en_e));
                    exp_v = (d >= P * SLOT);
                    chk($sformatf("cfg%0d_res_valid_d%0d", k, d), 64'(res_valid), 64'(exp_v));
                    if (exp_v) begin
                        chk($sformatf("cfg%0d_res_data", k), 64'(res_data), 64'(h.res[2*W*NE-1:0]));
                        if (d == P * SLOT) begin
                            stall     = first_res ? 5 : int'($urandom_range(0, 3));
                            first_res = 1'b0;
                        end
                        if (stall > 0) begin
                            res_ready = 1'b0;
                            stall--;
                        end else begin
                            res_ready = 1'b1;
                            last_hs   = cyc + 1;
                            void'(q.pop_front());
                        end
                    end else begin
                        res_ready = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].done && g_cfg[1].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) fail_now("global_timeout");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
